control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multicycle main control unit for the MIPS datapath. A Moore state machine sequences instruction fetch, decode, address/ALU execution, memory access and write-back over 3–5 cycles per instruction. It drives every datapath select, including the immediate-extension mode applied by the sign-extension unit, and waits on a simple memory-ready handshake. It sits beside the datapath top level and decodes the opcode field of the instruction register.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; held stable by the datapath after FETCH.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current read/write this cycle.
- `pc_en` out 1: PC load enable, equal to `pc_write | (pc_write_cond & zero)`.
- `iord` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: destination register; 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back source; 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A input; 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B input; 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct decode, 11 = logic by opcode.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ext_sel` out 1: immediate extension mode; 0 = sign, 1 = zero.
- `illegal` out 1: sticky illegal-opcode flag.
- `instr_count` out 32: count of completed instructions.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010. With the macro, also andi 001100 and ori 001101.
- All outputs except `illegal` and `instr_count` decode combinationally from `state`; any output not listed for a state is 0.
- IDLE (0): all outputs 0. Goes to FETCH unconditionally.
- FETCH (1): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Holds in FETCH until `mem_ready`, then goes to DECODE.
- DECODE (2): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 to compute the branch target.
  - lw/sw go to MEMADR; R-type to EXEC; beq to BRANCH; addi/andi/ori to IMMEXEC; j to JUMP.
  - Any other opcode: go to FETCH and set `illegal`.
- MEMADR (3): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, `ext_sel`=0. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD (4): `iord`=1, `mem_read`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB (5): `mem_to_reg`=1, `reg_write`=1, `reg_dst`=0. Goes to FETCH.
- MEMWR (6): `iord`=1, `mem_write`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC (7): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- ALUWB (8): `reg_dst`=1, `reg_write`=1. Goes to FETCH.
- BRANCH (9): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write_cond`=1. Goes to FETCH.
- IMMEXEC (10): `alu_src_a`=1, `alu_src_b`=10.
  - addi: `alu_op`=00, `ext_sel`=0.
  - andi/ori: `alu_op`=11, `ext_sel`=1.
  - Goes to IMMWB.
- IMMWB (11): `reg_dst`=0, `reg_write`=1, with the same `ext_sel` as IMMEXEC. Goes to FETCH.
- JUMP (12): `pc_source`=10, `pc_write`=1. Goes to FETCH.
- Unused encodings 13–15 go to FETCH with all outputs 0.
- `instr_count` increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IMMWB or JUMP.
  - Illegal opcodes do not increment it.
  - Wraps from 0xFFFFFFFF to 0.
- `illegal` is set on the clock edge leaving DECODE with an unknown opcode. It is cleared only by reset.

## Timing
- Reset: `state`=IDLE, `illegal`=0, `instr_count`=0; every output is 0, including `pc_en`.
- Reset asserted mid-instruction aborts immediately; no memory or register strobe survives reset.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw, R-type, addi/andi/ori: 4 cycles.
  - beq, j: 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Request signals stay asserted and stable while waiting.
- `pc_en` is combinational on `zero` in BRANCH only.

## Configuration
- `CTRL_ZERO_EXT_EN` defined: andi/ori are decoded as above, and `ext_sel`=1 in IMMEXEC/IMMWB for those opcodes.
- Not defined: andi/ori are illegal opcodes (DECODE goes to FETCH and sets `illegal`), and `ext_sel` is constantly 0.

## Test plan
- Reset release, `mem_ready`=1, opcode 000000 → states 0,1,2,7,8,1; `reg_write`=1 and `reg_dst`=1 only in ALUWB; `instr_count`=1.
- lw 100011 with `mem_ready` low for 2 cycles in MEMRD → `mem_read`=1 and `iord`=1 held for 3 cycles; MEMWB asserts `mem_to_reg`=1; total 7 cycles.
- beq with `zero`=1, then beq with `zero`=0 → `pc_en`=1 in the first BRANCH, 0 in the second; `pc_source`=01 in both.
- ori 001101 → `ext_sel`=1 and `alu_op`=11 in IMMEXEC with the macro; without the macro, `illegal`=1, `instr_count` unchanged, and FETCH follows DECODE.
- opcode 111111 → `illegal` rises after DECODE and stays 1 through a later valid j; the j asserts `pc_en`=1 with `pc_source`=10.
- `rst_n` pulsed low while in MEMWR → `mem_write` drops asynchronously to 0, `state`=0, `instr_count`=0.

Source files
------------

// File: rtl/control_multiciclo.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/write-back.
// Define CTRL_ZERO_EXT_EN to decode andi/ori with zero-extended immediates.
module control_multiciclo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        ext_sel,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_ALUWB   = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_IMMEXEC = 4'd10,
        ST_IMMWB   = 4'd11,
        ST_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

`ifdef CTRL_ZERO_EXT_EN
    localparam logic ZERO_EXT_EN = 1'b1;
`else
    localparam logic ZERO_EXT_EN = 1'b0;
`endif

    function automatic logic is_logic_imm(input logic [5:0] op);
        return ZERO_EXT_EN && ((op == OP_ANDI) || (op == OP_ORI));
    endfunction

    state_t      state_r;
    logic        illegal_r;
    logic [31:0] instr_count_r;
    logic        pc_write_s;
    logic        pc_write_cond_s;
    logic        logic_imm_s;

    assign logic_imm_s = is_logic_imm(opcode);

    // State sequencing, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            illegal_r     <= 1'b0;
            instr_count_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE:   state_r <= ST_FETCH;
                ST_FETCH:  state_r <= mem_ready ? ST_DECODE : ST_FETCH;
                ST_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_r <= ST_MEMADR;
                        OP_RTYPE:     state_r <= ST_EXEC;
                        OP_BEQ:       state_r <= ST_BRANCH;
                        OP_ADDI:      state_r <= ST_IMMEXEC;
                        OP_J:         state_r <= ST_JUMP;
                        default: begin
                            if (logic_imm_s) begin
                                state_r <= ST_IMMEXEC;
                            end else begin
                                state_r   <= ST_FETCH;
                                illegal_r <= 1'b1;
                            end
                        end
                    endcase
                end
                ST_MEMADR: begin
                    if (opcode == OP_LW) begin
                        state_r <= ST_MEMRD;
                    end else if (opcode == OP_SW) begin
                        state_r <= ST_MEMWR;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_MEMRD:  state_r <= mem_ready ? ST_MEMWB : ST_MEMRD;
                ST_MEMWR: begin
                    if (mem_ready) begin
                        state_r       <= ST_FETCH;
                        instr_count_r <= instr_count_r + 32'd1;
                    end else begin
                        state_r <= ST_MEMWR;
                    end
                end
                ST_EXEC:    state_r <= ST_ALUWB;
                ST_IMMEXEC: state_r <= ST_IMMWB;
                ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_IMMWB, ST_JUMP: begin
                    state_r       <= ST_FETCH;
                    instr_count_r <= instr_count_r + 32'd1;
                end
                default:    state_r <= ST_FETCH;
            endcase
        end
    end

    // Moore decode of datapath controls; only FETCH strobes and pc_en see live inputs
    always_comb begin
        iord            = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        ext_sel         = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write_s = mem_ready;
            end
            ST_DECODE:  alu_src_b = 2'b11;
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            ST_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ST_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_source       = 2'b01;
                pc_write_cond_s = 1'b1;
            end
            ST_IMMEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = logic_imm_s ? 2'b11 : 2'b00;
                ext_sel   = logic_imm_s;
            end
            ST_IMMWB: begin
                reg_write = 1'b1;
                ext_sel   = logic_imm_s;
            end
            ST_JUMP: begin
                pc_source  = 2'b10;
                pc_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en       = pc_write_s | (pc_write_cond_s & zero);
    assign illegal     = illegal_r;
    assign instr_count = instr_count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_control_multiciclo.sv
// Table-driven bench for control_multiciclo; honours CTRL_ZERO_EXT_EN like the design.
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, ext_sel, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] instr_count;
    logic [3:0]  state;
    logic [15:0] ctl;

    int errors = 0;
    int checks = 0;
    int hn = 0;

    control_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .ext_sel(ext_sel),
        .illegal(illegal), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_source,ext_sel}
    assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, ext_sel};

    localparam logic [15:0] W_ZERO   = 16'h0000;
    localparam logic [15:0] W_FETCH  = {9'b101010000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_FWAIT  = {9'b001000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_DECODE = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_MEMADR = {9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_MEMRD  = {9'b011000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_MEMWB  = {9'b000000110, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_MEMWR  = {9'b010100000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_EXEC   = {9'b000000001, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] W_ALUWB  = {9'b000001010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_BR_T   = {9'b100000001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [15:0] W_BR_N   = {9'b000000001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [15:0] W_IMMEXA = {9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_IMMWBA = {9'b000000010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] W_JUMP   = {9'b100000000, 2'b00, 2'b00, 2'b10, 1'b0};
`ifdef CTRL_ZERO_EXT_EN
    localparam logic [15:0] W_IMMEXL = {9'b000000001, 2'b10, 2'b11, 2'b00, 1'b1};
    localparam logic [15:0] W_IMMWBL = {9'b000000010, 2'b00, 2'b00, 2'b00, 1'b1};
`endif

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [3:0]  st;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [15:0] w;
        logic [31:0] cnt;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] st, input logic [5:0] op, input logic z,
                       input logic mr, input logic [15:0] w, input logic [31:0] cnt,
                       input logic ill);
        vec_t v;
        v.st = st; v.op = op; v.z = z; v.mr = mr; v.w = w; v.cnt = cnt; v.ill = ill;
        vecs.push_back(v);
    endtask

    // One cycle: drive inputs after the falling edge, compare 1 time unit later
    task automatic apply_row(input vec_t v, input string tag);
        @(negedge clk);
        opcode = v.op; zero = v.z; mem_ready = v.mr;
        #1;
        check($sformatf("%s.state", tag), {28'd0, state}, {28'd0, v.st});
        check($sformatf("%s.ctl", tag), {16'd0, ctl}, {16'd0, v.w});
        check($sformatf("%s.count", tag), instr_count, v.cnt);
        check($sformatf("%s.illegal", tag), {31'd0, illegal}, {31'd0, v.ill});
    endtask

    task automatic row(input logic [3:0] st, input logic [5:0] op, input logic z,
                       input logic mr, input logic [15:0] w, input logic [31:0] cnt,
                       input logic ill);
        vec_t v;
        v.st = st; v.op = op; v.z = z; v.mr = mr; v.w = w; v.cnt = cnt; v.ill = ill;
        apply_row(v, $sformatf("h%0d", hn));
        hn++;
    endtask

    // Assert reset away from clock edges, check the reset image, release after a rising edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check($sformatf("%s.state", tag), {28'd0, state}, 32'd0);
        check($sformatf("%s.ctl", tag), {16'd0, ctl}, 32'd0);
        check($sformatf("%s.count", tag), instr_count, 32'd0);
        check($sformatf("%s.illegal", tag), {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("%s.held", tag), {28'd0, state}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        logic ill;
        opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;

        // R-type, with one FETCH wait cycle
        add(4'd0, OP_R, 1'b0, 1'b1, W_ZERO,   32'd0, 1'b0);
        add(4'd1, OP_R, 1'b0, 1'b0, W_FWAIT,  32'd0, 1'b0);
        add(4'd1, OP_R, 1'b0, 1'b1, W_FETCH,  32'd0, 1'b0);
        add(4'd2, OP_R, 1'b1, 1'b1, W_DECODE, 32'd0, 1'b0);
        add(4'd7, OP_R, 1'b1, 1'b1, W_EXEC,   32'd0, 1'b0);
        add(4'd8, OP_R, 1'b0, 1'b1, W_ALUWB,  32'd0, 1'b0);
        // lw with two memory wait cycles
        add(4'd1, OP_LW, 1'b0, 1'b1, W_FETCH,  32'd1, 1'b0);
        add(4'd2, OP_LW, 1'b0, 1'b1, W_DECODE, 32'd1, 1'b0);
        add(4'd3, OP_LW, 1'b0, 1'b1, W_MEMADR, 32'd1, 1'b0);
        add(4'd4, OP_LW, 1'b0, 1'b0, W_MEMRD,  32'd1, 1'b0);
        add(4'd4, OP_LW, 1'b0, 1'b0, W_MEMRD,  32'd1, 1'b0);
        add(4'd4, OP_LW, 1'b0, 1'b1, W_MEMRD,  32'd1, 1'b0);
        add(4'd5, OP_LW, 1'b0, 1'b1, W_MEMWB,  32'd1, 1'b0);
        // sw with one memory wait cycle
        add(4'd1, OP_SW, 1'b0, 1'b1, W_FETCH,  32'd2, 1'b0);
        add(4'd2, OP_SW, 1'b1, 1'b1, W_DECODE, 32'd2, 1'b0);
        add(4'd3, OP_SW, 1'b0, 1'b1, W_MEMADR, 32'd2, 1'b0);
        add(4'd6, OP_SW, 1'b0, 1'b0, W_MEMWR,  32'd2, 1'b0);
        add(4'd6, OP_SW, 1'b0, 1'b1, W_MEMWR,  32'd2, 1'b0);
        // beq taken then not taken
        add(4'd1, OP_BEQ, 1'b0, 1'b1, W_FETCH,  32'd3, 1'b0);
        add(4'd2, OP_BEQ, 1'b0, 1'b1, W_DECODE, 32'd3, 1'b0);
        add(4'd9, OP_BEQ, 1'b1, 1'b1, W_BR_T,   32'd3, 1'b0);
        add(4'd1, OP_BEQ, 1'b0, 1'b1, W_FETCH,  32'd4, 1'b0);
        add(4'd2, OP_BEQ, 1'b0, 1'b1, W_DECODE, 32'd4, 1'b0);
        add(4'd9, OP_BEQ, 1'b0, 1'b1, W_BR_N,   32'd4, 1'b0);
        // addi
        add(4'd1,  OP_ADI, 1'b0, 1'b1, W_FETCH,  32'd5, 1'b0);
        add(4'd2,  OP_ADI, 1'b0, 1'b1, W_DECODE, 32'd5, 1'b0);
        add(4'd10, OP_ADI, 1'b1, 1'b1, W_IMMEXA, 32'd5, 1'b0);
        add(4'd11, OP_ADI, 1'b0, 1'b1, W_IMMWBA, 32'd5, 1'b0);
        add(4'd1,  OP_ORI, 1'b0, 1'b1, W_FETCH,  32'd6, 1'b0);

        #2;
        do_reset("por");
        for (int i = 0; i < vecs.size(); i++) begin
            apply_row(vecs[i], $sformatf("t%0d", i));
        end

        // ori: legal with zero extension, or illegal without
        c = 6;
        row(4'd2, OP_ORI, 1'b0, 1'b1, W_DECODE, c, 1'b0);
`ifdef CTRL_ZERO_EXT_EN
        row(4'd10, OP_ORI, 1'b0, 1'b1, W_IMMEXL, c, 1'b0);
        row(4'd11, OP_ORI, 1'b0, 1'b1, W_IMMWBL, c, 1'b0);
        c = 7;
        ill = 1'b0;
`else
        ill = 1'b1;
`endif
        row(4'd1, OP_BAD, 1'b0, 1'b1, W_FETCH,  c, ill);
        // unknown opcode, then a jump with the flag still sticky
        row(4'd2, OP_BAD, 1'b0, 1'b1, W_DECODE, c, ill);
        row(4'd1, OP_J,   1'b0, 1'b1, W_FETCH,  c, 1'b1);
        row(4'd2, OP_J,   1'b0, 1'b1, W_DECODE, c, 1'b1);
        row(4'd12, OP_J,  1'b0, 1'b1, W_JUMP,   c, 1'b1);
        c++;
        // sw stalled in MEMWR, then aborted by reset
        row(4'd1, OP_SW, 1'b0, 1'b1, W_FETCH,  c, 1'b1);
        row(4'd2, OP_SW, 1'b0, 1'b1, W_DECODE, c, 1'b1);
        row(4'd3, OP_SW, 1'b0, 1'b1, W_MEMADR, c, 1'b1);
        row(4'd6, OP_SW, 1'b0, 1'b0, W_MEMWR,  c, 1'b1);
        do_reset("midrst");
        row(4'd0, OP_R, 1'b0, 1'b1, W_ZERO,  32'd0, 1'b0);
        row(4'd1, OP_R, 1'b0, 1'b1, W_FETCH, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
